rr_sel_arbiter_32: RTL and testbench
====================================

// Module: rr_sel_arbiter_32
// PURPOSE
//  Round-robin arbiter that shares one 32:1 selection datapath among 32 requesters.
//  Grants one requester at a time and drives the 5-bit select of the downstream 32:1 mux.
//  Holds each grant until the owner releases it, or until a hold-limit timeout.
//  Sits between the requesting units and the shared mux in the CPU datapath.
// PARAMETERS
//  N         32  number of requesters (power of 2)
//  SELW      5   select width, = $clog2(N)
//  MAX_HOLD  16  max cycles a grant is held before forced preemption (>=2)
// PORTS
//  clk        in   1     clock, rising edge
//  reset_n    in   1     asynchronous, active-low reset
//  req        in   N     request vector, level-sensitive, bit i = requester i
//  release_i  in   1     current owner is done; pulse, meaningful only while sel_valid=1
//  grant      out  N     one-hot grant, registered; all zero when idle
//  sel        out  SELW  index of the granted requester, to the mux select; registered
//  sel_valid  out  1     a grant is active and sel is meaningful
//  preempt    out  1     1-cycle pulse: the current grant ended by MAX_HOLD timeout
// BEHAVIOUR
//  Clock and reset: one clock (clk); reset_n is asynchronous, active-low.
//  Reset values: grant=0, sel=0, sel_valid=0, preempt=0, ptr=0, hold_cnt=0, state=IDLE.
//  Internal state:
//    ptr [SELW-1:0]: highest-priority index.
//    hold_cnt [$clog2(MAX_HOLD)-1:0].
//  Pick function: the first set bit of req, searched circularly from ptr upward (ptr, ptr+1, ... wrapping at N-1 to 0).
//  FSM states: IDLE, GRANT.
//  IDLE:
//    - If |req: register winner w, set grant=1<<w, sel=w, sel_valid=1, hold_cnt=0, go to GRANT.
//    - Latency: request seen in cycle t gives the grant visible in cycle t+1.
//    - Else: stay in IDLE.
//  GRANT, owner o=sel. An end event is any of:
//    (a) release_i=1;
//    (b) req[o]=0 (owner withdrew);
//    (c) hold_cnt==MAX_HOLD-1 (timeout).
//    - If there is no end event: hold_cnt++; grant and sel stay stable.
//    - On an end event: ptr <= o+1 (mod N, natural wrap 31->0).
//    - Handover is zero-bubble. In the same cycle, pick from req & ~(1<<o) with the new ptr.
//      - If a winner exists: grant it next cycle, hold_cnt=0, stay in GRANT.
//      - If none: grant=0, sel_valid=0, go to IDLE. sel keeps its last value.
//    - preempt=1 for exactly the cycle after a timeout-caused end.
//      If (c) coincides with (a) or (b), it counts as a normal end and preempt=0.
//  Release outside GRANT is ignored.
//  Multiple simultaneous end causes count as one end; ptr advances once.
//  A sole requester that times out is re-granted after one IDLE cycle. This is because it is excluded from the handover pick.
//  Invariants:
//    - grant is one-hot or zero.
//    - grant==(sel_valid ? 1<<sel : 0).
//    - No requester waits more than (N-1)*MAX_HOLD+N cycles while continuously requesting.
//  Reset mid-grant: all outputs clear asynchronously; arbitration restarts from ptr=0 after deassertion.
// STRUCTURE
//  arb_pkg:
//    - typedef enum logic {IDLE, GRANT} arb_state_t.
//    - localparams ARB_N=32, ARB_SELW=5.
//  Sub-module rr_pick (combinational): in req[N-1:0], ptr[SELW-1:0]; out idx[SELW-1:0], found.
//    - Implemented as rotate-right by ptr, then find-first-set, then add ptr mod N.
//    - Instantiated once; the handover masking is applied at its input.
//  Top level: the FSM, ptr, hold_cnt and output registers. The only always_ff blocks are here.
// TESTING
//  1. Reset, then req=0x0000_0001 at t0
//     -> t1: grant=0x1, sel=0, sel_valid=1.
//     -> release_i at t3, req dropped -> t4: sel_valid=0, ptr=1.
//  2. ptr=0, req=0x8000_0011
//     -> sel=0; release -> sel=4; release -> sel=31; release -> sel=0 (wrap).
//     -> No idle cycle between the grants.
//  3. MAX_HOLD=16, req=0x3 held, no release
//     -> sel=0 for 16 cycles, preempt pulse, sel=1 for 16 cycles, then sel=0 again.
//  4. Owner 5 drops req[5] with release_i=0, req=0x0000_0120
//     -> next cycle sel=8, ptr advanced to 6.
//  5. Assert reset_n=0 mid-grant (sel=9), asynchronously to clk
//     -> grant=0, sel_valid=0 immediately.
//     -> After deassertion with req=0xFFFF_FFFF: first grant sel=0.
//  6. Random req/release for 10k cycles. Check:
//     -> one-hot grant;
//     -> grant/sel consistency;
//     -> starvation bound;
//     -> grant never goes to a non-requesting index.

Source files
------------

// File: rtl/arb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// arb_pkg: shared sizes and FSM state type for rr_sel_arbiter_32
// Rev 1.0
// ------------------------------------------------------------------
package arb_pkg;

  localparam int ARB_N    = 32;
  localparam int ARB_SELW = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_sel_arbiter_32_if.sv
`default_nettype none
// ------------------------------------------------------------------
// rr_sel_arbiter_32_if: requester/arbiter handshake and mux select bus
// Rev 1.0
// ------------------------------------------------------------------
interface rr_sel_arbiter_32_if
  import arb_pkg::*;
#(
  parameter int N    = ARB_N,
  parameter int SELW = ARB_SELW
);

  logic [N-1:0]    req;
  logic            release_i;
  logic [N-1:0]    grant;
  logic [SELW-1:0] sel;
  logic            sel_valid;
  logic            preempt;

  modport master (
    output req, release_i,
    input  grant, sel, sel_valid, preempt
  );

  modport slave (
    input  req, release_i,
    output grant, sel, sel_valid, preempt
  );

endinterface
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ------------------------------------------------------------------
// rr_pick: first set bit of req searched circularly upward from ptr
// Rev 1.0
// ------------------------------------------------------------------
module rr_pick
  import arb_pkg::*;
#(
  parameter int N    = ARB_N,
  parameter int SELW = ARB_SELW
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] idx,
  output logic            found
);

  logic [N-1:0]    rot;
  logic [SELW-1:0] first;

  // Rotate right by ptr; SELW-bit index arithmetic wraps modulo N.
  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req[SELW'(i) + ptr];
    end
  end

  always_comb begin
    first = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        first = SELW'(i);
      end
    end
  end

  assign idx   = first + ptr;
  assign found = |req;

endmodule
`default_nettype wire

// File: rtl/rr_sel_arbiter_32.sv
`default_nettype none
// ------------------------------------------------------------------
// rr_sel_arbiter_32: round-robin owner of a shared 32:1 select mux
// Rev 1.0
// ------------------------------------------------------------------
module rr_sel_arbiter_32
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int SELW     = ARB_SELW,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  rr_sel_arbiter_32_if.slave bus
);

  localparam int                HCW         = $clog2(MAX_HOLD);
  localparam logic [HCW-1:0]    c_hold_last = HCW'(MAX_HOLD - 1);
  localparam logic [N-1:0]      c_one       = N'(1);

  arb_state_t      state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic            sel_valid_q, sel_valid_d;
  logic            preempt_q, preempt_d;

  logic [N-1:0]    pick_req;
  logic [SELW-1:0] pick_ptr;
  logic [SELW-1:0] pick_idx;
  logic            pick_found;
  logic            end_rel, end_wd, end_to, end_any;

  // grant_q is zero in IDLE, so the owner mask only bites during handover.
  assign pick_req = bus.req & ~grant_q;
  assign pick_ptr = (state_q == GRANT) ? sel_q + SELW'(1) : ptr_q;

  rr_pick #(
    .N    (N),
    .SELW (SELW)
  ) u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign end_rel = bus.release_i;
  assign end_wd  = ~bus.req[sel_q];
  assign end_to  = (hold_cnt_q == c_hold_last);
  assign end_any = end_rel | end_wd | end_to;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    grant_d     = grant_q;
    sel_d       = sel_q;
    sel_valid_d = sel_valid_q;
    preempt_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = GRANT;
          grant_d     = c_one << pick_idx;
          sel_d       = pick_idx;
          sel_valid_d = 1'b1;
          hold_cnt_d  = '0;
        end
      end
      GRANT: begin
        if (!end_any) begin
          hold_cnt_d = hold_cnt_q + HCW'(1);
        end else begin
          ptr_d      = pick_ptr;
          // A timeout that coincides with a release or withdrawal is a normal end.
          preempt_d  = end_to & ~end_rel & ~end_wd;
          hold_cnt_d = '0;
          if (pick_found) begin
            grant_d = c_one << pick_idx;
            sel_d   = pick_idx;
          end else begin
            state_d     = IDLE;
            grant_d     = '0;
            sel_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      grant_q     <= '0;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      grant_q     <= grant_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      preempt_q   <= preempt_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.sel       = sel_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.preempt   = preempt_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_sel_arbiter_32.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_rr_sel_arbiter_32: directed scoreboard bench plus random invariants
// Rev 1.0
// ------------------------------------------------------------------
module tb_rr_sel_arbiter_32;

  localparam int c_bound = 31 * 16 + 32;

  typedef struct {
    int         tnum;
    logic       v;
    logic [4:0] s;
    logic       p;
  } exp_t;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  int   wait_cnt [32];
  exp_t sb [$];
  event chk_ev;

  rr_sel_arbiter_32_if bus_if ();

  rr_sel_arbiter_32 #(
    .MAX_HOLD (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic expect_out(input int tn, input logic ev, input logic [4:0] es, input logic ep);
    exp_t e;
    e.tnum = tn;
    e.v    = ev;
    e.s    = es;
    e.p    = ep;
    sb.push_back(e);
  endtask

  task automatic step(input int tn, input logic [31:0] r, input logic rel,
                      input logic ev, input logic [4:0] es, input logic ep);
    @(negedge clk);
    bus_if.req       = r;
    bus_if.release_i = rel;
    expect_out(tn, ev, es, ep);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Monitor: scoreboard pops plus per-cycle invariants.
  initial begin
    exp_t        e;
    logic [31:0] eg;
    logic [31:0] cg;
    logic        starve;
    for (int i = 0; i < 32; i++) wait_cnt[i] = 0;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (sb.size() > 0) begin
        e  = sb.pop_front();
        eg = e.v ? (32'd1 << e.s) : 32'd0;
        total++;
        if ({bus_if.grant, bus_if.sel, bus_if.sel_valid, bus_if.preempt} !== {eg, e.s, e.v, e.p}) begin
          bad++;
          $display("FAIL sb_test%0d: got grant=%h sel=%0d valid=%b preempt=%b, want grant=%h sel=%0d valid=%b preempt=%b",
                   e.tnum, bus_if.grant, bus_if.sel, bus_if.sel_valid, bus_if.preempt, eg, e.s, e.v, e.p);
        end
      end
      if (reset_n) begin
        total++;
        if (!$onehot0(bus_if.grant)) begin
          bad++;
          $display("FAIL onehot: got grant=%h, want one-hot or zero", bus_if.grant);
        end
        cg = bus_if.sel_valid ? (32'd1 << bus_if.sel) : 32'd0;
        total++;
        if (bus_if.grant !== cg) begin
          bad++;
          $display("FAIL grant_sel: got grant=%h, want %h from sel=%0d valid=%b",
                   bus_if.grant, cg, bus_if.sel, bus_if.sel_valid);
        end
        total++;
        if ((bus_if.grant & ~bus_if.req) != 32'd0) begin
          bad++;
          $display("FAIL nonreq_grant: got grant=%h with req=%h, want grant within req", bus_if.grant, bus_if.req);
        end
        starve = 1'b0;
        for (int i = 0; i < 32; i++) begin
          if (bus_if.req[i] && !bus_if.grant[i]) wait_cnt[i]++;
          else wait_cnt[i] = 0;
          if (wait_cnt[i] > c_bound) starve = 1'b1;
        end
        total++;
        if (starve) begin
          bad++;
          $display("FAIL starvation: got a wait above %0d cycles, want at most %0d", c_bound, c_bound);
          for (int i = 0; i < 32; i++) wait_cnt[i] = 0;
        end
      end else begin
        for (int i = 0; i < 32; i++) wait_cnt[i] = 0;
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish by time limit, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total            = 0;
    bad              = 0;
    reset_n          = 1'b0;
    bus_if.req       = '0;
    bus_if.release_i = 1'b0;
    repeat (2) @(negedge clk);
    step(0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single requester, release, then ptr=1 seen via next pick.
    step(1, 32'h1, 1'b0, 1'b1, 5'd0, 1'b0);
    step(1, 32'h1, 1'b0, 1'b1, 5'd0, 1'b0);
    step(1, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    step(1, 32'h3, 1'b0, 1'b1, 5'd1, 1'b0);
    step(1, 32'h0, 1'b0, 1'b0, 5'd1, 1'b0);
    do_reset();

    // Zero-bubble handovers with wrap.
    step(2, 32'h8000_0011, 1'b0, 1'b1, 5'd0,  1'b0);
    step(2, 32'h8000_0011, 1'b1, 1'b1, 5'd4,  1'b0);
    step(2, 32'h8000_0011, 1'b1, 1'b1, 5'd31, 1'b0);
    step(2, 32'h8000_0011, 1'b1, 1'b1, 5'd0,  1'b0);
    step(2, 32'h8000_0011, 1'b0, 1'b1, 5'd0,  1'b0);
    step(2, 32'h0,         1'b0, 1'b0, 5'd0,  1'b0);
    do_reset();

    // Timeout preemption between two requesters.
    for (int k = 0; k < 16; k++) step(3, 32'h3, 1'b0, 1'b1, 5'd0, 1'b0);
    for (int k = 0; k < 16; k++) step(3, 32'h3, 1'b0, 1'b1, 5'd1, (k == 0));
    step(3, 32'h3, 1'b0, 1'b1, 5'd0, 1'b1);
    step(3, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);

    // Sole requester timeout, one idle cycle, then timeout coinciding with release.
    for (int k = 0; k < 16; k++) step(7, 32'h1, 1'b0, 1'b1, 5'd0, 1'b0);
    step(7, 32'h1, 1'b0, 1'b0, 5'd0, 1'b1);
    for (int k = 0; k < 16; k++) step(7, 32'h1, 1'b0, 1'b1, 5'd0, 1'b0);
    step(7, 32'h1, 1'b1, 1'b0, 5'd0, 1'b0);

    // Owner withdraws without release.
    step(4, 32'h120, 1'b0, 1'b1, 5'd5, 1'b0);
    step(4, 32'h120, 1'b0, 1'b1, 5'd5, 1'b0);
    step(4, 32'h100, 1'b0, 1'b1, 5'd8, 1'b0);
    step(4, 32'h0,   1'b0, 1'b0, 5'd8, 1'b0);

    // Asynchronous reset mid-grant.
    step(5, 32'h200, 1'b0, 1'b1, 5'd9, 1'b0);
    step(5, 32'h200, 1'b0, 1'b1, 5'd9, 1'b0);
    @(negedge clk);
    #2;
    reset_n    = 1'b0;
    bus_if.req = '0;
    #1;
    expect_out(5, 1'b0, 5'd0, 1'b0);
    ->chk_ev;
    @(negedge clk);
    reset_n = 1'b1;
    step(5, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd0, 1'b0);
    step(5, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd1, 1'b0);
    step(5, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd1, 1'b0);
    step(5, 32'h0,         1'b0, 1'b0, 5'd1, 1'b0);

    // Random traffic; invariants are checked by the monitor.
    for (int k = 0; k < 10000; k++) begin
      @(negedge clk);
      bus_if.req       = $urandom;
      bus_if.release_i = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    bus_if.req       = '0;
    bus_if.release_i = 1'b0;
    repeat (3) @(negedge clk);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
